// File: rtl/mem_dma_if.sv
`default_nettype none
// ============================================================================
// mem_dma_if : single-port word memory bus between the DMA initiator and RAM.
// Rev 1.0
// ============================================================================
interface mem_dma_if;
   logic [31:0] mem_addr;
   logic        mem_rstrb;
   logic [31:0] mem_rdata;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;

   modport master (
      output mem_addr,
      output mem_rstrb,
      output mem_wdata,
      output mem_wmask,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_rstrb,
      input  mem_wdata,
      input  mem_wmask,
      output mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_dma.sv
`default_nettype none
// ============================================================================
// mem_dma : word-granular block fill/copy initiator with running write checksum.
// Rev 1.0
// ============================================================================
module mem_dma #(
   parameter int LEN_W = 16
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             start,
   input  wire logic             mode,
   input  wire logic [31:0]      src_addr,
   input  wire logic [31:0]      dst_addr,
   input  wire logic [LEN_W-1:0] len,
   input  wire logic [31:0]      fill_data,
   input  wire logic             abort,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [31:0]           checksum,
   mem_dma_if.master             bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WRITE = 3'd2,
      S_FILL  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_mode;
   logic [31:0]      r_src;
   logic [31:0]      r_dst;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_count;
   logic [31:0]      r_pattern;
   logic [31:0]      r_checksum;
   logic             r_aborted;

   logic             w_accept;
   logic             w_active;
   logic             w_write;
   logic             w_last;
   logic [LEN_W-1:0] w_count_inc;
   logic [31:0]      w_addr;
   logic [31:0]      w_wdata;
   logic [3:0]       w_wmask;
   logic             w_rstrb;

   // The aborted cycle still reports busy, so a new start is only taken after it.
   assign w_accept    = (r_state == S_IDLE) && !r_aborted && start;
   assign w_active    = (r_state == S_READ) || (r_state == S_WRITE) || (r_state == S_FILL);
   assign w_write     = (r_state == S_WRITE) || (r_state == S_FILL);
   assign w_count_inc = r_count + LEN_W'(1);
   assign w_last      = (w_count_inc == r_len);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Bus outputs decode from state only, so an async reset drops them at once.
   always_comb begin
      w_state_nxt = r_state;
      w_addr      = 32'h0;
      w_wdata     = 32'h0;
      w_wmask     = 4'h0;
      w_rstrb     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (len == '0)   w_state_nxt = S_DONE;
               else if (mode)   w_state_nxt = S_READ;
               else             w_state_nxt = S_FILL;
            end
         end
         S_READ: begin
            w_addr      = r_src;
            w_rstrb     = 1'b1;
            w_state_nxt = abort ? S_IDLE : S_WRITE;
         end
         S_WRITE: begin
            w_addr      = r_dst;
            w_wmask     = 4'hF;
            w_wdata     = bus.mem_rdata;
            w_state_nxt = abort ? S_IDLE : (w_last ? S_DONE : S_READ);
         end
         S_FILL: begin
            w_addr      = r_dst;
            w_wmask     = 4'hF;
            w_wdata     = r_pattern;
            w_state_nxt = abort ? S_IDLE : (w_last ? S_DONE : S_FILL);
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode     <= 1'b0;
         r_src      <= 32'h0;
         r_dst      <= 32'h0;
         r_len      <= '0;
         r_count    <= '0;
         r_pattern  <= 32'h0;
         r_checksum <= 32'h0;
         r_aborted  <= 1'b0;
      end else begin
         r_aborted <= w_active && abort;
         if (w_accept) begin
            r_mode     <= mode;
            r_src      <= src_addr & 32'hFFFF_FFFC;
            r_dst      <= dst_addr & 32'hFFFF_FFFC;
            r_len      <= len;
            r_count    <= '0;
            r_pattern  <= fill_data;
            r_checksum <= 32'h0;
         end else if (w_write) begin
            // Memory commits on this edge even under abort, so the word is counted.
            r_checksum <= r_checksum + w_wdata;
            r_dst      <= r_dst + 32'd4;
            r_count    <= w_count_inc;
            if (r_mode) r_src <= r_src + 32'd4;
         end
      end
   end

   assign busy          = (r_state != S_IDLE) || r_aborted;
   assign done          = (r_state == S_DONE);
   assign aborted       = r_aborted;
   assign checksum      = r_checksum;
   assign bus.mem_addr  = w_addr;
   assign bus.mem_wdata = w_wdata;
   assign bus.mem_wmask = w_wmask;
   assign bus.mem_rstrb = w_rstrb;

endmodule
`default_nettype wire
